// File: rtl/hex_line_writer.sv
// hex_line_writer: formats a 4-char label plus a 32-bit value as a 16-char
// text line and streams it, one character per write, into a 64-char
// (4 lines x 16 chars) text buffer.
//
// Line layout: LLLL:HHHHHHHH___  (label, colon, 8 hex digits, 3 spaces)
//
// Handshake: start is a request pulse and is only honoured in IDLE while done
// is low. Once accepted, line_sel/label/value are captured and the upstream
// may change them freely. busy is high from the cycle after acceptance through
// the done cycle. we/wr_addr/din form a write-only strobe interface with no
// back-pressure: the buffer must accept a write on every cycle that we is high.
module hex_line_writer #(
    parameter int GAP   = 0,   // idle cycles between character writes (0..255)
    parameter bit UPPER = 1'b1 // 1: hex A-F uppercase, 0: a-f lowercase
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  line_sel,
    input  logic [31:0] label,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        we,
    output logic [5:0]  wr_addr,
    output logic [7:0]  din
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Last value of the gap counter before returning to WRITE. With GAP=0
    // the GAP state is never entered, so the value is irrelevant there.
    localparam logic [7:0] GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t      state,    state_nxt;
    logic [1:0]  line_r,   line_nxt;
    logic [31:0] label_r,  label_nxt;
    logic [31:0] value_r,  value_nxt;
    logic [3:0]  col,      col_nxt;
    logic [7:0]  gap_cnt,  gap_nxt;
    logic        busy_nxt;
    logic        done_nxt;
    logic        we_nxt;
    logic [5:0]  addr_nxt;
    logic [7:0]  din_nxt;

    logic [7:0]  label_byte;
    logic [3:0]  nibble;
    logic [7:0]  char_cur;

    // Non-printable label bytes would show as garbage on the OLED font,
    // so they are replaced by '?'.
    function automatic logic [7:0] sanitize(input logic [7:0] b);
        if ((b < 8'h20) || (b > 8'h7E)) begin
            return 8'h3F;
        end
        return b;
    endfunction

    // One hex nibble to its ASCII digit, case chosen by UPPER.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        if (UPPER) begin
            return 8'h41 + {4'h0, n} - 8'd10;
        end
        return 8'h61 + {4'h0, n} - 8'd10;
    endfunction

    // Select the label byte for columns 0-3, leftmost byte first.
    always_comb begin
        label_byte = 8'h00;
        case (col[1:0])
            2'd0:    label_byte = label_r[31:24];
            2'd1:    label_byte = label_r[23:16];
            2'd2:    label_byte = label_r[15:8];
            default: label_byte = label_r[7:0];
        endcase
    end

    // Select the value nibble for columns 5-12, most significant first.
    always_comb begin
        nibble = 4'h0;
        case (col)
            4'd5:    nibble = value_r[31:28];
            4'd6:    nibble = value_r[27:24];
            4'd7:    nibble = value_r[23:20];
            4'd8:    nibble = value_r[19:16];
            4'd9:    nibble = value_r[15:12];
            4'd10:   nibble = value_r[11:8];
            4'd11:   nibble = value_r[7:4];
            4'd12:   nibble = value_r[3:0];
            default: nibble = 4'h0;
        endcase
    end

    // Character for the current column.
    always_comb begin
        char_cur = 8'h20;
        if (col < 4'd4) begin
            char_cur = sanitize(label_byte);
        end else if (col == 4'd4) begin
            char_cur = 8'h3A;
        end else if (col <= 4'd12) begin
            char_cur = hex_char(nibble);
        end else begin
            char_cur = 8'h20;
        end
    end

    // Next-state and next-output logic; every register holds by default and
    // the write strobe and done pulse default low.
    always_comb begin
        state_nxt = state;
        line_nxt  = line_r;
        label_nxt = label_r;
        value_nxt = value_r;
        col_nxt   = col;
        gap_nxt   = gap_cnt;
        busy_nxt  = (state != S_IDLE);
        done_nxt  = 1'b0;
        we_nxt    = 1'b0;
        addr_nxt  = wr_addr;
        din_nxt   = din;

        case (state)
            S_IDLE: begin
                // done is still visible in the first IDLE cycle; a start
                // coinciding with it is dropped so a requester that reacts
                // to done gets a clean one-cycle turnaround.
                if (start && !done) begin
                    line_nxt  = line_sel;
                    label_nxt = label;
                    value_nxt = value;
                    col_nxt   = 4'd0;
                    gap_nxt   = 8'd0;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                we_nxt   = 1'b1;
                addr_nxt = {line_r, col};
                din_nxt  = char_cur;
                if (col == 4'd15) begin
                    state_nxt = S_DONE;
                end else begin
                    col_nxt = col + 4'd1;
                    if (GAP > 0) begin
                        gap_nxt   = 8'd0;
                        state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_WRITE;
                end else begin
                    gap_nxt = gap_cnt + 8'd1;
                end
            end
            S_DONE: begin
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, captured request and registered outputs; reset abandons any
    // line in progress without a recovery write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            line_r  <= 2'd0;
            label_r <= 32'd0;
            value_r <= 32'd0;
            col     <= 4'd0;
            gap_cnt <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            we      <= 1'b0;
            wr_addr <= 6'd0;
            din     <= 8'd0;
        end else begin
            state   <= state_nxt;
            line_r  <= line_nxt;
            label_r <= label_nxt;
            value_r <= value_nxt;
            col     <= col_nxt;
            gap_cnt <= gap_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            we      <= we_nxt;
            wr_addr <= addr_nxt;
            din     <= din_nxt;
        end
    end

endmodule

// File: doc/hex_line_writer.md
Name: hex_line_writer

Overview:
- Upstream feeder for the 64-character OLED text buffer (4 lines x 16 chars).
- On request, formats one 32-bit value plus a 4-char ASCII label into a 16-char text line.
- Streams that line into the buffer's write port: one character per write, 16 writes in total.
- Intended for on-board debug display of pipeline registers and PC. A top level drives the buffer's we / wr_addr / din from this block.

Parameters:
GAP, 0, idle cycles inserted between consecutive character writes (0..255)
UPPER, 1, 1 = hex digits A-F as 0x41-0x46; 0 = a-f as 0x61-0x66

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  request pulse; sampled only in IDLE
line_sel  input  2  target line 0..3, captured at start
label  input  32  four ASCII chars; bits [31:24] = leftmost char; captured at start
value  input  32  value to print, captured at start
busy  output  1  high from the cycle after an accepted start through the DONE cycle
done  output  1  one-cycle pulse after the last write
we  output  1  character write strobe to the buffer
wr_addr  output  6  buffer address = {line_sel, col[3:0]}
din  output  8  ASCII character for wr_addr

Behaviour:
- Reset:
  - Asynchronous; one clock; reset is asynchronous and active-high.
  - Takes effect immediately, including mid-line: state = IDLE, and busy, done, we, wr_addr, din, col and the gap counter all = 0.
  - A line interrupted by reset is left partially written. No recovery write is issued.
- FSM states: IDLE, WRITE, GAP, DONE.
- IDLE:
  - start=1 captures line_sel, label and value into registers.
  - Clears col to 0, then enters WRITE.
  - start=0 keeps the FSM in IDLE.
- WRITE:
  - we=1, wr_addr={line_r, col}, din=char(col), all registered outputs.
  - If col==15, go to DONE.
  - Otherwise col <= col+1; go to GAP if GAP>0, else stay in WRITE.
- GAP:
  - we=0; counts GAP cycles, then returns to WRITE.
  - wr_addr and din hold their last values.
- DONE:
  - done=1 and we=0 for exactly one cycle, then IDLE.
  - busy falls in the IDLE cycle that follows.
- Character map per column:
  - col 0-3: label bytes, leftmost first. Any byte <0x20 or >0x7E is replaced by 0x3F ('?').
  - col 4: 0x3A (':').
  - col 5-12: hex nibbles of value, MSB first. col 5 = value[31:28], col 12 = value[3:0].
  - Nibble 0-9 maps to 0x30+n. Nibble 10-15 maps to 0x41+(n-10) if UPPER=1, else 0x61+(n-10).
  - col 13-15: 0x20 (space).
- Timing with GAP=0, start sampled high on edge 0:
  - we is high on the cycles following edges 1..16.
  - done is high after edge 17.
  - busy is high from edge 1 through edge 17.
- Timing with GAP=G: the 16 writes are separated by G idle cycles each. done follows the last write, after a total of 16+15G+1 cycles from start.
- start while busy (WRITE/GAP/DONE) is ignored, with no queuing. Inputs changing while busy have no effect; only the captured copies are used.
- start in the same cycle as done is ignored. start asserted in the following IDLE cycle is accepted.
- Address wrap: col is 4 bits. Writes never cross into another line; line 3 col 15 = address 63.
- we is never high in IDLE, GAP or DONE. Exactly 16 we pulses occur per accepted start.

Test Plan:
- Reset / idle: hold rst=1, then release with start=0 for 20 cycles -> we=0, busy=0, done=0, wr_addr=0, din=0 throughout.
- Basic line, GAP=0, UPPER=1: start with line_sel=2, label="PC  " (0x50432020), value=0x1234ABCD -> 16 consecutive we pulses.
  - Addresses 32..47 in order.
  - din sequence 50 43 20 20 3A 31 32 33 34 41 42 43 44 20 20 20.
  - done one cycle after address 47; busy drops on the next cycle.
- Lowercase and sanitising, UPPER=0: label=0x0A41427F, value=0xFFFFFFFF, line_sel=0 -> din = 3F 41 42 3F 3A then eight 66, then 20 20 20.
- Gap and busy-start, GAP=3: start, then pulse start again mid-line with different value and line_sel.
  - Exactly 16 writes, 3 idle cycles apart, using the first value only.
  - done at cycle 62 after start; the second start is ignored.
- Reset mid-operation: assert rst asynchronously between clock edges after the 7th write (address {line_sel,6}) -> we, busy and done go to 0 immediately.
  - After release, no writes occur until a new start.
  - A new start with line_sel=3 writes addresses 48..63.
- Back-to-back: start on the cycle done is high -> ignored. start on the next cycle -> accepted; the first write follows one cycle later.
